mac_accum_16bit: RTL and testbench

- Dot-product accumulator directly downstream of the 8-bit pipelined multiplier.
- Consumes the multiplier's 16-bit product stream (`mul_out`, qualified by `mul_en_out`) and sums a run-time-configurable number of consecutive products into one frame result.
- Finished results go into a 2-entry output FIFO with valid/ready handshake, so the downstream consumer may stall.
- The multiplier has no backpressure; results that cannot be stored are dropped and flagged.

---
 rtl/mac_accum_16bit.sv | 170 +++++++++++++++++
 tb/tb_mac_accum_16bit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_16bit.sv
// Frame accumulator behind the 8-bit multiplier: sums len_cfg products per frame
// and queues each frame result in a 2-entry valid/ready output FIFO.
module mac_accum_16bit #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned ACC_W = 20,
   parameter int unsigned LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [LEN_W-1:0] len_cfg,
   input  logic             acc_clr,
   input  logic             prod_vld,
   input  logic [IN_W-1:0]  prod_data,
   output logic             res_vld,
   output logic [ACC_W-1:0] res_data,
   output logic             res_sat,
   input  logic             res_rdy,
   output logic             busy,
   output logic             ovf_err
);

   localparam int unsigned SUM_W = ACC_W + 1;
   localparam int unsigned CNT_W = LEN_W + 1;

   typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_len;
   logic               r_sat;
   logic               r_busy;

   logic [ACC_W-1:0]   r_mem_d [2];
   logic               r_mem_s [2];
   logic               r_wptr;
   logic               r_rptr;
   logic [1:0]         r_fcnt;
   logic               r_res_vld;
   logic [ACC_W-1:0]   r_res_data;
   logic               r_res_sat;
   logic               r_ovf;

   logic [CNT_W-1:0]   w_len_cfg_eff;
   logic [CNT_W-1:0]   w_len_cur;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [ACC_W-1:0]   w_base;
   logic [SUM_W-1:0]   w_sum;
   logic               w_ovfl;
   logic [ACC_W-1:0]   w_res;
   logic               w_res_sat;
   logic               w_accept_c;
   logic               w_done_c;

   logic               w_pop;
   logic               w_full;
   logic               w_push;
   logic [1:0]         w_fcnt_nxt;
   logic               w_rptr_nxt;
   logic [ACC_W-1:0]   w_head_d;
   logic               w_head_s;

   // A first product starts from zero; a saturated sum stays pinned at all-ones.
   assign w_len_cfg_eff = (len_cfg == '0) ? {1'b1, {LEN_W{1'b0}}} : CNT_W'(len_cfg);
   assign w_len_cur     = (r_state == ACC) ? r_len : w_len_cfg_eff;
   assign w_cnt_nxt     = (r_state == ACC) ? r_cnt + CNT_W'(1) : CNT_W'(1);
   assign w_base        = (r_state == ACC) ? r_acc : '0;
   assign w_sum         = SUM_W'(w_base) + SUM_W'(prod_data);
   assign w_ovfl        = w_sum[SUM_W-1];
   assign w_res         = w_ovfl ? '1 : w_sum[ACC_W-1:0];
   assign w_res_sat     = ((r_state == ACC) && r_sat) || w_ovfl;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ACC);
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (acc_clr)
         w_state_nxt = IDLE;
      else if (prod_vld)
         w_state_nxt = w_done_c ? IDLE : ACC;
   end

   // Output decode
   always_comb begin
      w_accept_c = 1'b0;
      w_done_c   = 1'b0;
      if (prod_vld && !acc_clr) begin
         w_accept_c = 1'b1;
         w_done_c   = (w_cnt_nxt == w_len_cur);
      end
   end

   // Accumulator datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_len <= '0;
         r_sat <= 1'b0;
      end else if (acc_clr) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_sat <= 1'b0;
      end else if (w_accept_c) begin
         if (r_state == IDLE)
            r_len <= w_len_cfg_eff;
         r_acc <= w_res;
         r_cnt <= w_cnt_nxt;
         r_sat <= w_res_sat;
      end
   end

   // Output FIFO: a push is allowed into a full FIFO only when the head pops.
   assign w_pop      = r_res_vld && res_rdy;
   assign w_full     = (r_fcnt == 2'd2);
   assign w_push     = w_done_c && (!w_full || w_pop);
   assign w_fcnt_nxt = r_fcnt + 2'(w_push) - 2'(w_pop);
   assign w_rptr_nxt = r_rptr ^ w_pop;
   assign w_head_d   = (w_push && (r_wptr == w_rptr_nxt)) ? w_res : r_mem_d[w_rptr_nxt];
   assign w_head_s   = (w_push && (r_wptr == w_rptr_nxt)) ? w_res_sat : r_mem_s[w_rptr_nxt];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_mem_d[i] <= '0;
            r_mem_s[i] <= 1'b0;
         end
         r_wptr     <= 1'b0;
         r_rptr     <= 1'b0;
         r_fcnt     <= '0;
         r_res_vld  <= 1'b0;
         r_res_data <= '0;
         r_res_sat  <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem_d[r_wptr] <= w_res;
            r_mem_s[r_wptr] <= w_res_sat;
            r_wptr          <= ~r_wptr;
         end
         r_rptr    <= w_rptr_nxt;
         r_fcnt    <= w_fcnt_nxt;
         r_res_vld <= (w_fcnt_nxt != '0);
         if (w_fcnt_nxt != '0) begin
            r_res_data <= w_head_d;
            r_res_sat  <= w_head_s;
         end
         if (w_done_c && w_full && !w_pop)
            r_ovf <= 1'b1;
      end
   end

   assign res_vld  = r_res_vld;
   assign res_data = r_res_data;
   assign res_sat  = r_res_sat;
   assign busy     = r_busy;
   assign ovf_err  = r_ovf;

endmodule

// File: tb/tb_mac_accum_16bit.sv
// Self-checking bench: default (ACC_W=20) and saturating (ACC_W=17) instances share
// stimulus; a frame-level model is compared every cycle, plus literal spot checks.
module tb_mac_accum_16bit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  len_cfg;
   logic        acc_clr;
   logic        prod_vld;
   logic [15:0] prod_data;
   logic        res_rdy;

   logic        v0, s0, b0, o0;
   logic [19:0] d0;
   logic        v1, s1, b1, o1;
   logic [16:0] d1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mac_accum_16bit #(.IN_W(16), .ACC_W(20), .LEN_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .len_cfg(len_cfg), .acc_clr(acc_clr),
      .prod_vld(prod_vld), .prod_data(prod_data), .res_vld(v0), .res_data(d0),
      .res_sat(s0), .res_rdy(res_rdy), .busy(b0), .ovf_err(o0));

   mac_accum_16bit #(.IN_W(16), .ACC_W(17), .LEN_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .len_cfg(len_cfg), .acc_clr(acc_clr),
      .prod_vld(prod_vld), .prod_data(prod_data), .res_vld(v1), .res_data(d1),
      .res_sat(s1), .res_rdy(res_rdy), .busy(b1), .ovf_err(o1));

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   // Frame-level model: running sum, frame counter, and a list of queued results
   bit     m_in   [2] = '{0, 0};
   int     m_len  [2] = '{0, 0};
   int     m_cnt  [2] = '{0, 0};
   longint m_sum  [2] = '{0, 0};
   bit     m_sat  [2] = '{0, 0};
   longint m_q_d  [2][2];
   bit     m_q_s  [2][2];
   int     m_q_n  [2] = '{0, 0};
   longint e_data [2] = '{0, 0};
   bit     e_sat  [2] = '{0, 0};
   bit     m_ovf  [2] = '{0, 0};

   function automatic longint maxv(input int k);
      return (k == 0) ? 64'd1048575 : 64'd131071;
   endfunction

   task automatic model_step(input int k);
      bit pop;
      bit done;
      pop  = (m_q_n[k] != 0) && res_rdy;
      done = 1'b0;
      if (acc_clr) begin
         m_in[k] = 1'b0;
      end else if (prod_vld) begin
         if (!m_in[k]) begin
            m_len[k] = (len_cfg == 0) ? 16 : int'(len_cfg);
            m_sum[k] = 0;
            m_sat[k] = 1'b0;
            m_cnt[k] = 0;
         end
         m_sum[k] += longint'(prod_data);
         if (m_sum[k] > maxv(k)) begin
            m_sum[k] = maxv(k);
            m_sat[k] = 1'b1;
         end
         m_cnt[k]++;
         if (m_cnt[k] == m_len[k]) begin
            done    = 1'b1;
            m_in[k] = 1'b0;
         end else begin
            m_in[k] = 1'b1;
         end
      end
      if (pop) begin
         m_q_d[k][0] = m_q_d[k][1];
         m_q_s[k][0] = m_q_s[k][1];
         m_q_n[k]--;
      end
      if (done) begin
         if (m_q_n[k] < 2) begin
            m_q_d[k][m_q_n[k]] = m_sum[k];
            m_q_s[k][m_q_n[k]] = m_sat[k];
            m_q_n[k]++;
         end else begin
            m_ovf[k] = 1'b1;
         end
      end
      if (m_q_n[k] != 0) begin
         e_data[k] = m_q_d[k][0];
         e_sat[k]  = m_q_s[k][0];
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_in[k] = 1'b0; m_cnt[k] = 0; m_sum[k] = 0; m_sat[k] = 1'b0;
            m_q_n[k] = 0; e_data[k] = 0; e_sat[k] = 1'b0; m_ovf[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) model_step(k);
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("vld0",  longint'(v0), longint'(m_q_n[0] != 0));
         chk("data0", longint'(d0), e_data[0]);
         chk("sat0",  longint'(s0), longint'(e_sat[0]));
         chk("busy0", longint'(b0), longint'(m_in[0]));
         chk("ovf0",  longint'(o0), longint'(m_ovf[0]));
         chk("vld1",  longint'(v1), longint'(m_q_n[1] != 0));
         chk("data1", longint'(d1), e_data[1]);
         chk("sat1",  longint'(s1), longint'(e_sat[1]));
         chk("busy1", longint'(b1), longint'(m_in[1]));
         chk("ovf1",  longint'(o1), longint'(m_ovf[1]));
      end
   end

   // One product cycle; returns 1 time unit after the sampling edge.
   task automatic drive(input logic v, input logic [15:0] d, input logic c);
      @(negedge clk); #2;
      prod_vld = v; prod_data = d; acc_clr = c;
      @(posedge clk); #1;
      prod_vld = 1'b0; acc_clr = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_vld"},  longint'(v0 | v1), 0);
      chk({tag, "_data"}, longint'(d0) + longint'(d1), 0);
      chk({tag, "_sat"},  longint'(s0 | s1), 0);
      chk({tag, "_busy"}, longint'(b0 | b1), 0);
      chk({tag, "_ovf"},  longint'(o0 | o1), 0);
   endtask

   initial begin
      rst_n = 1'b0; len_cfg = '0; acc_clr = 1'b0; prod_vld = 1'b0;
      prod_data = '0; res_rdy = 1'b1;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      #2 rst_n = 1'b1;

      // Basic frame
      len_cfg = 4'd4;
      drive(1, 16'd100, 0); chk("t1_busy_a", longint'(b0), 1);
      drive(1, 16'd200, 0); chk("t1_busy_b", longint'(b0), 1);
      drive(1, 16'd300, 0); chk("t1_busy_c", longint'(b0), 1);
      drive(1, 16'd400, 0);
      chk("t1_vld",  longint'(v0), 1);
      chk("t1_data", longint'(d0), 1000);
      chk("t1_sat",  longint'(s0), 0);
      chk("t1_busy_end", longint'(b0), 0);
      drive(0, 16'd0, 0);
      chk("t1_vld_pulse", longint'(v0), 0);

      // Gapped input, length 0 means 16
      len_cfg = 4'd0;
      for (int i = 0; i < 16; i++) begin
         drive(1, 16'd65025, 0);
         if (i < 15) begin
            drive(0, 16'd0, 0);
            chk("t2_busy_gap", longint'(b0), 1);
         end
      end
      chk("t2_data0", longint'(d0), 1040400);
      chk("t2_sat0",  longint'(s0), 0);
      chk("t2_data1", longint'(d1), 131071);
      chk("t2_sat1",  longint'(s1), 1);
      drive(0, 16'd0, 0);

      // Backpressure and overflow
      res_rdy = 1'b0; len_cfg = 4'd1;
      drive(1, 16'd5, 0); chk("t3_head5", longint'(d0), 5);
      drive(1, 16'd6, 0);
      drive(1, 16'd7, 0);
      chk("t3_vld",   longint'(v0), 1);
      chk("t3_hold5", longint'(d0), 5);
      chk("t3_ovf",   longint'(o0), 1);
      res_rdy = 1'b1;
      drive(0, 16'd0, 0); chk("t3_head6", longint'(d0), 6);
      drive(0, 16'd0, 0);
      chk("t3_empty", longint'(v0), 0);
      chk("t3_ovf_sticky", longint'(o0), 1);

      // Abort mid-frame
      len_cfg = 4'd3;
      drive(1, 16'd10, 0);
      drive(1, 16'd20, 0); chk("t4_busy", longint'(b0), 1);
      drive(1, 16'd30, 1);
      chk("t4_busy_clr", longint'(b0), 0);
      chk("t4_no_res",   longint'(v0), 0);
      drive(1, 16'd1, 0);
      drive(1, 16'd2, 0);
      drive(1, 16'd3, 0);
      chk("t4_vld",  longint'(v0), 1);
      chk("t4_data", longint'(d0), 6);
      drive(0, 16'd0, 0);

      // Saturation on the narrow instance
      len_cfg = 4'd3;
      repeat (3) drive(1, 16'd65025, 0);
      chk("t5_data1", longint'(d1), 131071);
      chk("t5_sat1",  longint'(s1), 1);
      chk("t5_data0", longint'(d0), 195075);
      chk("t5_sat0",  longint'(s0), 0);
      repeat (3) drive(1, 16'd1, 0);
      chk("t5_next_data1", longint'(d1), 3);
      chk("t5_next_sat1",  longint'(s1), 0);
      drive(0, 16'd0, 0);

      // Reset mid-frame with one result queued
      res_rdy = 1'b0; len_cfg = 4'd1;
      drive(1, 16'd50, 0);
      len_cfg = 4'd3;
      drive(1, 16'd1, 0);
      drive(1, 16'd2, 0);
      chk("t6_busy", longint'(b0), 1);
      chk("t6_queued", longint'(v0), 1);
      @(negedge clk); #2 rst_n = 1'b0;
      #1 chk_all_zero("t6_rst");
      @(negedge clk); #2 rst_n = 1'b1; res_rdy = 1'b1;
      len_cfg = 4'd2;
      drive(1, 16'd7, 0);
      drive(1, 16'd8, 0);
      chk("t6_vld",  longint'(v0), 1);
      chk("t6_data", longint'(d0), 15);
      repeat (3) drive(0, 16'd0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
